sum_display_mux: RTL and testbench

Parametrised adder with registered result, sequential binary-to-BCD conversion and a time-multiplexed multi-digit seven-segment driver. Accepts WIDTH-bit operands plus carry-in on a start strobe, produces the sum and carry-out, converts the (WIDTH+1)-bit result to decimal digits and scans them onto a common-anode display. It is the board-level successor to the 3-bit adder with single-digit display, and sits between the board switches/buttons and the display pins.

---
 rtl/sumdisp_pkg.sv | 51 +++++
 rtl/seg7_decoder.sv | 38 +++
 rtl/sum_display_mux.sv | 162 ++++++++++++++++
 tb/tb_sum_display_mux.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sumdisp_pkg.sv
// Shared types, segment codes and constant helpers for sum_display_mux.
// SUMDISP_HEX_EN (used by the top and decoder) swaps decimal display for hex.
package sumdisp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Decimal digits needed to print 2^bits - 1.
   function automatic int dec_digits(input int bits);
      longint v;
      int d;
      v = (longint'(1) << bits) - 1;
      d = 1;
      while (v >= 10) begin
         v = v / 10;
         d++;
      end
      return d;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// 4-bit digit code to active-low seven-segment pattern, with blanking.
// Codes A..F decode only when SUMDISP_HEX_EN is defined.
module seg7_decoder
   import sumdisp_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
`ifdef SUMDISP_HEX_EN
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/sum_display_mux.sv
// Adder with registered sum, serial binary-to-BCD conversion and a scanned
// common-anode display. Define SUMDISP_HEX_EN to show the sum in hex instead.
module sum_display_mux
   import sumdisp_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              ci,
   input  logic              start,
   output logic [WIDTH-1:0]  s,
   output logic              co,
   output logic              busy,
   output logic              done,
   output logic [6:0]        sseg,
   output logic [DIGITS-1:0] an
);

   localparam int SW     = WIDTH + 1;
   localparam int DISP_W = 4 * DIGITS;
   localparam int SCAN_W = clog2(SCAN_DIV);
   localparam int IDX_W  = clog2(DIGITS);
`ifdef SUMDISP_HEX_EN
   localparam int REQ_DIGITS = (SW + 3) / 4;
`else
   localparam int REQ_DIGITS = dec_digits(SW);
   localparam int BCD_W      = 4 * REQ_DIGITS;
   localparam int CNT_W      = clog2(SW + 1);
`endif

   if (DIGITS < REQ_DIGITS || WIDTH < 1 || SCAN_DIV < 1) begin : g_param_check
      $error("sum_display_mux: DIGITS too small for WIDTH, or WIDTH/SCAN_DIV < 1");
   end

   // Handshake: start is a request sampled only in IDLE (busy=0, done=0); there
   // is no ready back-pressure, so a start seen in CONV or DONE is dropped.
   state_t            state_q, state_d;
   logic [SW-1:0]     sum_q, sum_d;
   logic [DISP_W-1:0] disp_q;
   logic              accept, last_step;

   assign sum_d  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
   assign accept = (state_q == IDLE) && start;
   assign {co, s} = sum_q;

`ifdef SUMDISP_HEX_EN
   assign last_step = 1'b1;
`else
   logic [SW-1:0]    shift_q;
   logic [BCD_W-1:0] bcd_q, bcd_step;
   logic [CNT_W-1:0] cnt_q;

   assign last_step = (cnt_q == CNT_W'(1));

   // One double-dabble step: bias every nibble >= 5, then shift in the next sum bit.
   always_comb begin
      logic [BCD_W-1:0] adj;
      adj = bcd_q;
      for (int i = 0; i < REQ_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_step = BCD_W'({adj, shift_q[SW-1]});
   end
`endif

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef SUMDISP_HEX_EN
            if (start) state_d = DONE;
`else
            if (start) state_d = CONV;
`endif
         end
         CONV: begin
            busy = 1'b1;
            if (last_step) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sum_q   <= '0;
         disp_q  <= '0;
`ifndef SUMDISP_HEX_EN
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) sum_q <= sum_d;
`ifdef SUMDISP_HEX_EN
         if (accept) disp_q <= DISP_W'(sum_d);
`else
         if (accept) begin
            shift_q <= sum_d;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(SW);
         end else if (state_q == CONV) begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_step;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (last_step) disp_q <= DISP_W'(bcd_step);
         end
`endif
      end
   end

   // Free-running digit scanner, unaffected by the conversion FSM.
   logic [SCAN_W-1:0] scan_q;
   logic [IDX_W-1:0]  dig_q;
   logic              scan_wrap;

   assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q <= '0;
         dig_q  <= '0;
      end else if (scan_wrap) begin
         scan_q <= '0;
         dig_q  <= (dig_q == IDX_W'(DIGITS - 1)) ? '0 : dig_q + IDX_W'(1);
      end else begin
         scan_q <= scan_q + SCAN_W'(1);
      end
   end

   logic [DISP_W-1:0] upper;
   logic              blank;

   // A digit is a leading zero when it and everything above it are zero.
   always_comb begin
      upper = disp_q >> {dig_q, 2'b00};
      blank = (dig_q != '0) && (upper == '0);
      an    = '1;
      an[dig_q] = 1'b0;
   end

   seg7_decoder u_dec (
      .code  (upper[3:0]),
      .blank (blank),
      .seg   (sseg)
   );

endmodule

// File: tb/tb_sum_display_mux.sv
// Directed bench for sum_display_mux with a timeline model and literal pins.
module tb_sum_display_mux;

  localparam int WIDTH    = 4;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int SW       = WIDTH + 1;
`ifdef SUMDISP_HEX_EN
  localparam int LAT  = 0;
  localparam int BASE = 16;
  localparam int BUSY_CYCLES = 0;
`else
  localparam int LAT  = SW;
  localparam int BASE = 10;
  localparam int BUSY_CYCLES = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic ci = 1'b0;
  logic start = 1'b0;
  logic [WIDTH-1:0] s;
  logic co, busy, done;
  logic [6:0] sseg;
  logic [DIGITS-1:0] an;

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  sum_display_mux #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .start (start),
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done),
    .sseg  (sseg),
    .an    (an)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Model: age counts edges since an accepted request; the display takes the
  // queued sum when the age reaches the conversion latency.
  int m_age = -1;
  int m_sum = 0;
  int m_disp = 0;
  int m_ticks = 0;
  logic [WIDTH:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = -1;
      m_sum = 0;
      m_disp = 0;
      m_ticks = 0;
      exp_q.delete();
    end else begin
      m_ticks++;
      if (m_age == LAT) m_age = -1;
      else if (m_age >= 0) m_age++;
      else if (start) begin
        m_sum = int'(a) + int'(b) + int'(ci);
        exp_q.push_back(m_sum[WIDTH:0]);
        m_age = 0;
      end
      if (m_age == LAT && exp_q.size() > 0) m_disp = int'(exp_q.pop_front());
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin : cmp
    int idx, p, dig;
    logic [6:0] e_seg;
    logic [DIGITS-1:0] e_an;
    idx = (m_ticks / SCAN_DIV) % DIGITS;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * BASE;
    dig = (m_disp / p) % BASE;
    e_seg = (idx > 0 && m_disp < p) ? 7'b1111111 : seg_tab[dig];
    e_an = ~(DIGITS'(1) << idx);
    check("s", int'(s), m_sum % (1 << WIDTH));
    check("co", int'(co), m_sum >> WIDTH);
    check("busy", int'(busy), (m_age >= 0 && m_age < LAT) ? 1 : 0);
    check("done", int'(done), (m_age == LAT) ? 1 : 0);
    check("an", int'(an), int'(e_an));
    check("sseg", int'(sseg), int'(e_seg));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int av, input int bv, input int cv);
    a = WIDTH'(av);
    b = WIDTH'(bv);
    ci = cv[0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit drop_start, output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (drop_start) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic check_digit(input int idx, input logic [6:0] exp_seg, input string name);
    bit found;
    logic [DIGITS-1:0] want;
    found = 1'b0;
    want = ~(DIGITS'(1) << idx);
    for (int n = 0; n < 4 * DIGITS * SCAN_DIV + 4 && !found; n++) begin
      @(negedge clk);
      if (an == want) found = 1'b1;
    end
    check({name, "_an"}, int'(an), int'(want));
    check(name, int'(sseg), int'(exp_seg));
  endtask

  initial begin
    int bc;
    bit seen;
    bit done_seen;

    repeat (2) @(negedge clk);
    check("rst_s", int'(s), 0);
    check("rst_co", int'(co), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_an", int'(an), 'b1110);
    check("rst_sseg", int'(sseg), 'b1000000);
    tick();
    rst_n = 1'b1;

    // 9 + 8 + 1 = 18
    do_op(9, 8, 1);
    wait_done(1'b0, bc, seen);
    check("op1_done_seen", int'(seen), 1);
    check("op1_busy_cycles", bc, BUSY_CYCLES);
    check("op1_s", int'(s), 'b0010);
    check("op1_co", int'(co), 1);
`ifdef SUMDISP_HEX_EN
    check_digit(0, 7'b0100100, "op1_dig0");
`else
    check_digit(0, 7'b0000000, "op1_dig0");
`endif
    check_digit(1, 7'b1111001, "op1_dig1");
    check_digit(2, 7'b1111111, "op1_dig2");
    check_digit(3, 7'b1111111, "op1_dig3");

    // 15 + 15 + 1 = 31
    do_op(15, 15, 1);
    wait_done(1'b0, bc, seen);
    check("op2_done_seen", int'(seen), 1);
    check("op2_s", int'(s), 'b1111);
    check("op2_co", int'(co), 1);
`ifdef SUMDISP_HEX_EN
    check_digit(0, 7'b0001110, "op2_dig0");
    check_digit(1, 7'b1111001, "op2_dig1");
`else
    check_digit(0, 7'b1111001, "op2_dig0");
    check_digit(1, 7'b0110000, "op2_dig1");
`endif

    // a second start right after acceptance must be dropped
    do_op(15, 15, 1);
    a = '0;
    b = '0;
    ci = 1'b0;
    start = 1'b1;
    wait_done(1'b1, bc, seen);
    check("op3_done_seen", int'(seen), 1);
    check("op3_s", int'(s), 'b1111);
    check("op3_co", int'(co), 1);
`ifdef SUMDISP_HEX_EN
    check_digit(0, 7'b0001110, "op3_dig0");
`else
    check_digit(0, 7'b1111001, "op3_dig0");
    check_digit(1, 7'b0110000, "op3_dig1");
`endif

    // reset during conversion
    do_op(3, 4, 0);
`ifndef SUMDISP_HEX_EN
    tick();
`endif
    rst_n = 1'b0;
    #1;
    check("abort_s", int'(s), 0);
    check("abort_co", int'(co), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_an", int'(an), 'b1110);
    check("abort_sseg", int'(sseg), 'b1000000);
    tick();
    rst_n = 1'b1;

    // scan order after reset release, with no done from the aborted request
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
      check("scan_an", int'(an), int'(an_pat[(k / SCAN_DIV) % DIGITS]));
    end
    check("abort_no_done", int'(done_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
